// File: rtl/key_expand_iter.sv
// key_expand_iter: iterative AES-128 key schedule, one round key per clock.
// Emits round keys 0..10 after a Start pulse, then holds round key 10.
// Optional build macro KEY_CACHE_EN adds an 11-entry round-key cache with a
// combinational read port (RdIdx/RdKey) and a CacheValid flag.
module key_expand_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Start,
  input  logic [127:0] Key,
  output logic         Busy,
  output logic [127:0] RoundKey,
  output logic [3:0]   Round,
  output logic         RoundKeyValid,
  output logic         Done
`ifdef KEY_CACHE_EN
  ,
  input  logic [3:0]   RdIdx,
  output logic [127:0] RdKey,
  output logic         CacheValid
`endif
);

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned LAST_ROUND = 10;
  localparam int unsigned NUM_KEYS   = 11;

  typedef enum logic [0:0] {IDLE, EXPAND} state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   rk_q, rk_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               rkv_q, rkv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         rcon_q, rcon_d;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // GF(2^8) multiply, shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // AES S-box: multiplicative inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Next round key from the current one and the round constant
  function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] rk,
                                                input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, temp;
    w0   = rk[127:96];
    w1   = rk[95:64];
    w2   = rk[63:32];
    w3   = rk[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^
           {rcon, 24'h000000};
    w0   = w0 ^ temp;
    w1   = w1 ^ w0;
    w2   = w2 ^ w1;
    w3   = w3 ^ w2;
    next_key = {w0, w1, w2, w3};
  endfunction

  // Next-state and next-output logic for the IDLE/EXPAND sequencer
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    rkv_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (Start) begin
          rk_d    = Key;
          round_d = '0;
          rkv_d   = 1'b1;
          busy_d  = 1'b1;
          rcon_d  = 8'h01;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        busy_d = 1'b1;
        if (round_q < RND_W'(LAST_ROUND)) begin
          rk_d    = next_key(rk_q, rcon_q);
          round_d = round_q + RND_W'(1);
          rkv_d   = 1'b1;
          rcon_d  = xtime(rcon_q);
          done_d  = (round_q == RND_W'(LAST_ROUND - 1));
        end else begin
          // Round 10 was on the outputs this cycle; return to IDLE holding it
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      rkv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rkv_q   <= rkv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rcon_q  <= rcon_d;
    end
  end

  assign Busy          = busy_q;
  assign RoundKey      = rk_q;
  assign Round         = round_q;
  assign RoundKeyValid = rkv_q;
  assign Done          = done_q;

`ifdef KEY_CACHE_EN
  logic [KEY_W-1:0] cache_q [NUM_KEYS];
  logic [KEY_W-1:0] cache_d [NUM_KEYS];
  logic             cache_valid_q, cache_valid_d;

  // Capture each emitted round key; track whether a full schedule is held
  always_comb begin
    cache_d       = cache_q;
    cache_valid_d = cache_valid_q;
    if (rkv_q && (round_q <= RND_W'(LAST_ROUND))) cache_d[round_q] = rk_q;
    if ((state_q == IDLE) && Start) cache_valid_d = 1'b0;
    else if (done_q)               cache_valid_d = 1'b1;
  end

  // Cache storage with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) cache_q[i] <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      cache_q       <= cache_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  // Combinational read port; out-of-range indices read as zero
  always_comb begin
    RdKey = '0;
    if (RdIdx <= RND_W'(LAST_ROUND)) RdKey = cache_q[RdIdx];
  end

  assign CacheValid = cache_valid_q;
`endif

endmodule

// File: tb/tb_key_expand_iter.sv
// Self-checking bench for key_expand_iter against a word-level FIPS-197
// key-expansion model. Cache checks compile in when KEY_CACHE_EN is defined.
module tb_key_expand_iter;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         Start;
  logic [127:0] Key;
  logic         Busy;
  logic [127:0] RoundKey;
  logic [3:0]   Round;
  logic         RoundKeyValid;
  logic         Done;
`ifdef KEY_CACHE_EN
  logic [3:0]   RdIdx;
  logic [127:0] RdKey;
  logic         CacheValid;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_k  [11];
  logic [127:0] obs_k  [11];

  key_expand_iter dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Key(Key), .Busy(Busy),
    .RoundKey(RoundKey), .Round(Round), .RoundKeyValid(RoundKeyValid), .Done(Done)
`ifdef KEY_CACHE_EN
    , .RdIdx(RdIdx), .RdKey(RdKey), .CacheValid(CacheValid)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  // S-box built from its definition: brute-force inverse, then bitwise affine map
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
               inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Classic 44-word expansion; round r key is words 4r..4r+3
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word_m({t[23:0], t[31:24]}) ^ {RCON[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called in the round-0 cycle; walks to and ends in the round-10 cycle
  task automatic check_run(input logic [127:0] k, input bit hold, input bit scramble);
    model_expand(k);
    for (int r = 0; r <= 10; r++) begin
      obs_k[r] = RoundKey;
      chk($sformatf("rk%0d", r), RoundKey, exp_k[r]);
      chk($sformatf("round%0d", r), 128'(Round), 128'(r));
      chk($sformatf("rkv%0d", r), 128'(RoundKeyValid), 128'(1));
      chk($sformatf("busy%0d", r), 128'(Busy), 128'(1));
      chk($sformatf("done%0d", r), 128'(Done), 128'(r == 10));
      if (!hold) Start = 1'b0;
      if (scramble) Key = rand128();
      if (r < 10) step();
    end
  endtask

  task automatic check_idle(input string tag, input logic [127:0] rk, input logic [3:0] rnd);
    chk({tag, "_busy"}, 128'(Busy), 128'(0));
    chk({tag, "_rkv"}, 128'(RoundKeyValid), 128'(0));
    chk({tag, "_done"}, 128'(Done), 128'(0));
    chk({tag, "_rk"}, RoundKey, rk);
    chk({tag, "_round"}, 128'(Round), 128'(rnd));
  endtask

  initial begin
    logic [127:0] k;
    rst_n = 1'b0;
    Start = 1'b0;
    Key   = '0;
`ifdef KEY_CACHE_EN
    RdIdx = 4'd3;
`endif
    build_sbox();
    step();
    step();
    check_idle("reset", 128'h0, 4'd0);
`ifdef KEY_CACHE_EN
    chk("reset_cv", 128'(CacheValid), 128'(0));
    chk("reset_rdkey", RdKey, 128'h0);
`endif
    rst_n = 1'b1;
    step();

    // FIPS-197 vector, with Key scrambled while expanding
    Key = FIPS_KEY;
    Start = 1'b1;
    step();
    check_run(FIPS_KEY, 1'b0, 1'b1);
    chk("fips_r1", obs_k[1], FIPS_R1);
    chk("fips_r10", obs_k[10], FIPS_R10);
    step();
    check_idle("fips_idle", FIPS_R10, 4'd10);
`ifdef KEY_CACHE_EN
    chk("cv_set", 128'(CacheValid), 128'(1));
    RdIdx = 4'd1;  #1; chk("rd1", RdKey, FIPS_R1);
    RdIdx = 4'd10; #1; chk("rd10", RdKey, FIPS_R10);
    RdIdx = 4'd15; #1; chk("rd15", RdKey, 128'h0);
`endif

    // All-zero key, then 20 idle cycles holding round key 10
    Key = '0;
    Start = 1'b1;
    step();
`ifdef KEY_CACHE_EN
    chk("cv_clr", 128'(CacheValid), 128'(0));
`endif
    check_run(128'h0, 1'b0, 1'b0);
    chk("zero_r10", RoundKey, ZERO_R10);
    for (int i = 0; i < 20; i++) begin
      step();
      check_idle($sformatf("hold%0d", i), ZERO_R10, 4'd10);
    end

    // Start held high: restart only from IDLE, Done every 12 cycles
    k = rand128();
    Key = k;
    Start = 1'b1;
    step();
    check_run(k, 1'b1, 1'b0);
    step();
    check_idle("cont_gap", exp_k[10], 4'd10);
    k = rand128();
    Key = k;
    step();
    check_run(k, 1'b1, 1'b0);
    Start = 1'b0;
    step();
    check_idle("cont_end", exp_k[10], 4'd10);

    // Reset at round 5 aborts the run with no Done
    Key = FIPS_KEY;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_round", 128'(Round), 128'(5));
    rst_n = 1'b0;
    step();
    check_idle("abort", 128'h0, 4'd0);
`ifdef KEY_CACHE_EN
    chk("abort_cv", 128'(CacheValid), 128'(0));
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("nodone%0d", i), 128'(Done), 128'(0));
    end
    Start = 1'b1;
    step();
    check_run(FIPS_KEY, 1'b0, 1'b0);
    chk("refips_r10", RoundKey, FIPS_R10);
    step();
    check_idle("refips_idle", FIPS_R10, 4'd10);

    // Random keys with Key disturbed during expansion
    for (int n = 0; n < 3; n++) begin
      k = rand128();
      Key = k;
      Start = 1'b1;
      step();
      check_run(k, 1'b0, 1'b1);
      step();
      check_idle($sformatf("rnd%0d", n), exp_k[10], 4'd10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
